traffic_request_front: RTL and testbench

TRAFFIC_REQUEST_FRONT -- requirements
Module: traffic_request_front

---
 rtl/traffic_request_front.sv | 132 +++++++++++++
 tb/tb_traffic_request_front.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_request_front.sv
// Debounced car-sensor / pedestrian-button front end feeding service requests to a two-way light controller.
// Define REQ_COUNT_EN to build the saturating accepted-request counters; otherwise cnt_a/cnt_b read zero.
module traffic_request_front #(
    parameter int unsigned TICK_DIV  = 4,
    parameter int unsigned DEB_TICKS = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       raw_sa,
    input  logic       raw_sb,
    input  logic [1:0] light_a,
    input  logic [1:0] light_b,
    output logic       SA,
    output logic       SB,
    output logic [7:0] cnt_a,
    output logic [7:0] cnt_b
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [7:0]  DEB_LAST  = 8'(DEB_TICKS - 1);

    typedef enum logic [1:0] {IDLE, PEND, SERVED} state_t;

    logic [15:0]     pcnt_q, pcnt_d;
    logic            tick;
    logic [1:0]      warm_q;
    logic [1:0]      raw, green, req;
    logic [1:0][7:0] cnt;

    assign raw   = {raw_sb, raw_sa};
    assign green = {light_b == 2'b10, light_a == 2'b10};
    assign tick  = (pcnt_q == TICK_LAST);
    assign pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;

    // warm_q[1] marks the synchronizer output as a genuine post-reset sample
    always_ff @(posedge CLK) begin
        if (RST) begin
            pcnt_q <= '0;
            warm_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            warm_q <= {warm_q[0], 1'b1};
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic       s1_q, s2_q;
        logic       stable_q, stable_d;
        logic       arm_q, arm_d;
        logic       req_q, req_d;
        logic [7:0] dcnt_q, dcnt_d;
        logic       accept, ev;
        state_t     st_q, st_d;

        always_comb begin
            stable_d = stable_q;
            dcnt_d   = dcnt_q;
            accept   = 1'b0;
            if (tick) begin
                if (s2_q != stable_q) begin
                    if (dcnt_q == DEB_LAST) begin
                        accept   = 1'b1;
                        stable_d = s2_q;
                        dcnt_d   = '0;
                    end else begin
                        dcnt_d = dcnt_q + 8'd1;
                    end
                end else begin
                    dcnt_d = '0;
                end
            end
        end

        // An input held high through reset must be seen low before it can raise a request
        assign arm_d = arm_q | (warm_q[1] & ~s2_q);
        assign ev    = accept & s2_q & arm_q;

        always_comb begin
            st_d = st_q;
            case (st_q)
                IDLE:    if (ev) st_d = green[c] ? SERVED : PEND;
                PEND:    if (green[c]) st_d = SERVED;
                SERVED:  if (!green[c]) st_d = IDLE;
                default: st_d = IDLE;
            endcase
        end

        assign req_d = (st_d == PEND);

        always_ff @(posedge CLK) begin
            if (RST) begin
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                stable_q <= 1'b0;
                dcnt_q   <= '0;
                arm_q    <= 1'b0;
                st_q     <= IDLE;
                req_q    <= 1'b0;
            end else begin
                s1_q     <= raw[c];
                s2_q     <= s1_q;
                stable_q <= stable_d;
                dcnt_q   <= dcnt_d;
                arm_q    <= arm_d;
                st_q     <= st_d;
                req_q    <= req_d;
            end
        end

        assign req[c] = req_q;

`ifdef REQ_COUNT_EN
        logic [7:0] cnt_q;
        always_ff @(posedge CLK) begin
            if (RST) begin
                cnt_q <= '0;
            end else if (st_q == IDLE && st_d == PEND && cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
        assign cnt[c] = cnt_q;
`else
        assign cnt[c] = 8'd0;
`endif
    end

    assign SA    = req[0];
    assign SB    = req[1];
    assign cnt_a = cnt[0];
    assign cnt_b = cnt[1];

endmodule

// File: tb/tb_traffic_request_front.sv
// Randomized and directed bench for traffic_request_front against a behavioural request model.
// Expected counter values follow REQ_COUNT_EN the same way the design does.
module tb_traffic_request_front;

    localparam int TD  = 4;
    localparam int DEB = 3;

    logic       CLK = 1'b0;
    logic       RST, raw_sa, raw_sb;
    logic [1:0] light_a, light_b;
    logic       SA, SB;
    logic [7:0] cnt_a, cnt_b;

    int nvec = 0;
    int errs = 0;

    traffic_request_front #(.TICK_DIV(TD), .DEB_TICKS(DEB)) dut (
        .CLK(CLK), .RST(RST), .raw_sa(raw_sa), .raw_sb(raw_sb),
        .light_a(light_a), .light_b(light_b),
        .SA(SA), .SB(SB), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    always #5 CLK = ~CLK;

    // Reference: cycles since reset, a two-deep raw history, a run of mismatched ticks,
    // a "seen low since reset" flag, and a per-direction request phase.
    int m_cyc;
    bit m_h1[2], m_h2[2], m_stab[2], m_seen_low[2], m_sa[2];
    int m_run[2], m_phase[2], m_cnt[2];  // phase: 0 idle, 1 waiting for green, 2 served

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0d, want %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step();
        bit rw[2];
        bit gr[2];
        bit tick;
        rw[0] = raw_sa;  rw[1] = raw_sb;
        gr[0] = (light_a == 2'b10);
        gr[1] = (light_b == 2'b10);
        if (RST) begin
            m_cyc = 0;
            for (int c = 0; c < 2; c++) begin
                m_h1[c] = 0; m_h2[c] = 0; m_stab[c] = 0; m_seen_low[c] = 0;
                m_run[c] = 0; m_phase[c] = 0; m_cnt[c] = 0; m_sa[c] = 0;
            end
            return;
        end
        tick = (m_cyc % TD) == TD - 1;
        for (int c = 0; c < 2; c++) begin
            bit ev;
            ev = 0;
            if (tick) begin
                if (m_h2[c] != m_stab[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB) begin
                        ev = m_h2[c] && m_seen_low[c];
                        m_stab[c] = m_h2[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            if (m_cyc >= 2 && !m_h2[c]) m_seen_low[c] = 1;
            m_h2[c] = m_h1[c];
            m_h1[c] = rw[c];
            if (m_phase[c] == 0) begin
                if (ev && gr[c]) m_phase[c] = 2;
                else if (ev) begin
                    m_phase[c] = 1;
`ifdef REQ_COUNT_EN
                    if (m_cnt[c] < 255) m_cnt[c]++;
`endif
                end
            end else if (m_phase[c] == 1) begin
                if (gr[c]) m_phase[c] = 2;
            end else if (!gr[c]) begin
                m_phase[c] = 0;
            end
            m_sa[c] = (m_phase[c] == 1);
        end
        m_cyc++;
    endtask

    task automatic step(input bit r, input bit ra, input bit rb, input logic [1:0] la, input logic [1:0] lb);
        RST = r; raw_sa = ra; raw_sb = rb; light_a = la; light_b = lb;
        model_step();
        @(negedge CLK);
        chk("SA", {7'd0, SA}, {7'd0, m_sa[0]});
        chk("SB", {7'd0, SB}, {7'd0, m_sa[1]});
        chk("cnt_a", cnt_a, 8'(m_cnt[0]));
        chk("cnt_b", cnt_b, 8'(m_cnt[1]));
    endtask

    task automatic hold(input bit ra, input bit rb, input logic [1:0] la, input logic [1:0] lb, input int n);
        repeat (n) step(1'b0, ra, rb, la, lb);
    endtask

    logic [7:0] exp_sat;

    initial begin
        repeat (3) step(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        chk("rst_sa", {7'd0, SA}, 8'd0);
        chk("rst_cnt_a", cnt_a, 8'd0);
        hold(0, 0, 2'b00, 2'b00, 10);

        // long press against red, then green clears the request one edge later
        hold(1, 0, 2'b00, 2'b00, 16);
        chk("lat_sa", {7'd0, SA}, 8'd1);
        hold(1, 0, 2'b00, 2'b00, 24);
        chk("held_sa", {7'd0, SA}, 8'd1);
        hold(1, 0, 2'b10, 2'b00, 1);
        chk("green_drop_sa", {7'd0, SA}, 8'd0);
        hold(0, 0, 2'b00, 2'b00, 20);

        // short glitch on B never becomes a request
        hold(0, 1, 2'b00, 2'b00, 6);
        hold(0, 0, 2'b00, 2'b00, 20);
        chk("glitch_sb", {7'd0, SB}, 8'd0);
        chk("glitch_cnt_b", cnt_b, 8'd0);

        // press while already green is served silently; next press on red is requested
        hold(1, 0, 2'b10, 2'b00, 20);
        chk("green_press_sa", {7'd0, SA}, 8'd0);
        hold(0, 0, 2'b00, 2'b00, 20);
        hold(1, 0, 2'b00, 2'b00, 18);
        chk("second_press_sa", {7'd0, SA}, 8'd1);
        hold(1, 0, 2'b10, 2'b00, 2);
        hold(0, 0, 2'b11, 2'b00, 20);

        // simultaneous presses on both directions
        hold(1, 1, 2'b00, 2'b00, 16);
        chk("both_sa", {7'd0, SA}, 8'd1);
        chk("both_sb", {7'd0, SB}, 8'd1);
        hold(0, 0, 2'b10, 2'b10, 3);
        hold(0, 0, 2'b00, 2'b00, 20);

        // reset while pending with the button held: no request until released and pressed again
        hold(1, 0, 2'b00, 2'b00, 18);
        step(1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        chk("rst_pend_sa", {7'd0, SA}, 8'd0);
        chk("rst_pend_cnt", cnt_a, 8'd0);
        hold(1, 0, 2'b00, 2'b00, 40);
        chk("held_after_rst_sa", {7'd0, SA}, 8'd0);
        hold(0, 0, 2'b00, 2'b00, 20);
        hold(1, 0, 2'b00, 2'b00, 18);
        chk("repress_sa", {7'd0, SA}, 8'd1);

        // random segments, including code 2'b11 and occasional resets
        for (int i = 0; i < 150; i++) begin
            bit ra, rb;
            logic [1:0] la, lb;
            int n;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            la = 2'($urandom_range(0, 3));
            lb = 2'($urandom_range(0, 3));
            n  = $urandom_range(1, 30);
            if ($urandom_range(0, 29) == 0) step(1'b1, ra, rb, la, lb);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 7) == 0) la = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) lb = 2'($urandom_range(0, 3));
                step(1'b0, ra, rb, la, lb);
            end
        end

        // 300 requested-and-served presses on A
        step(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        hold(0, 0, 2'b00, 2'b00, 10);
        for (int k = 0; k < 300; k++) begin
            hold(1, 0, 2'b00, 2'b00, 18);
            hold(1, 0, 2'b10, 2'b00, 2);
            hold(0, 0, 2'b00, 2'b00, 18);
        end
`ifdef REQ_COUNT_EN
        exp_sat = 8'd255;
`else
        exp_sat = 8'd0;
`endif
        chk("sat_cnt_a", cnt_a, exp_sat);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
